// File: rtl/vga_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vga_write_arbiter
// Purpose  : Round-robin owner of the shared VGA framebuffer write port.
// Options  : define VGA_ARB_TIMEOUT_EN to force release after MAX_HOLD cycles.
// Revision : 1.0
// ============================================================================
module vga_write_arbiter #(
    parameter int N        = 3,
    parameter int MAX_HOLD = 4096
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   done,
    input  logic [N-1:0]   wen_in,
    input  logic [8*N-1:0] x_in,
    input  logic [7*N-1:0] y_in,
    input  logic [3*N-1:0] color_in,
    output logic [N-1:0]   gnt,
    output logic [1:0]     owner,
    output logic           busy,
    output logic [7:0]     x_out,
    output logic [6:0]     y_out,
    output logic [2:0]     color_out,
    output logic           writeEn,
    output logic           timeout
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    if (N < 2 || N > 4 || MAX_HOLD < 2) begin : g_bad_params
        $error("vga_write_arbiter: N must be 2..4 and MAX_HOLD >= 2");
    end

    logic [1:0]   state;
    logic [1:0]   rr_ptr;
    logic [1:0]   pick;
    logic [1:0]   pick_lo;
    logic [1:0]   pick_hi;
    logic         hit_hi;
    logic [N-1:0] pick_onehot;
    logic [1:0]   next_ptr;
    logic         own_req;
    logic         own_done;
    logic         own_wen;
    logic [7:0]   own_x;
    logic [6:0]   own_y;
    logic [2:0]   own_color;
    logic         normal_release;
    logic         force_release;

    // Lowest requester at or above rr_ptr wins; otherwise wrap to the lowest overall.
    always_comb begin
        pick_lo = 2'd0;
        pick_hi = 2'd0;
        hit_hi  = 1'b0;
        for (int j = N - 1; j >= 0; j--) begin
            if (req[j]) begin
                pick_lo = 2'(j);
                if (2'(j) >= rr_ptr) begin
                    pick_hi = 2'(j);
                    hit_hi  = 1'b1;
                end
            end
        end
        pick        = hit_hi ? pick_hi : pick_lo;
        pick_onehot = N'(1) << pick;
    end

    always_comb begin
        own_req   = 1'b0;
        own_done  = 1'b0;
        own_wen   = 1'b0;
        own_x     = 8'd0;
        own_y     = 7'd0;
        own_color = 3'd0;
        for (int j = 0; j < N; j++) begin
            if (owner == 2'(j)) begin
                own_req   = req[j];
                own_done  = done[j];
                own_wen   = wen_in[j];
                own_x     = x_in[8*j +: 8];
                own_y     = y_in[7*j +: 7];
                own_color = color_in[3*j +: 3];
            end
        end
    end

    assign next_ptr       = (owner == 2'(N - 1)) ? 2'd0 : owner + 2'd1;
    assign normal_release = own_done || !own_req;

    assign busy      = (state == S_GRANT);
    assign writeEn   = busy && own_wen;
    assign x_out     = busy ? own_x     : 8'd0;
    assign y_out     = busy ? own_y     : 7'd0;
    assign color_out = busy ? own_color : 3'd0;

`ifdef VGA_ARB_TIMEOUT_EN
    localparam int HW = $clog2(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    logic [HW-1:0] hold_cnt;

    assign force_release = busy && (hold_cnt == HOLD_LAST) && !normal_release;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hold_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            timeout <= force_release;
            if (state == S_IDLE) begin
                hold_cnt <= '0;
            end else if (busy && hold_cnt != HOLD_LAST) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end
`else
    assign force_release = 1'b0;
    assign timeout       = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= S_IDLE;
            gnt    <= '0;
            owner  <= 2'd0;
            rr_ptr <= 2'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|req) begin
                        gnt   <= pick_onehot;
                        owner <= pick;
                        state <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (normal_release || force_release) begin
                        gnt    <= '0;
                        rr_ptr <= next_ptr;
                        state  <= S_GAP;
                    end
                end
                S_GAP:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_write_arbiter
// Purpose  : Directed + random bench for vga_write_arbiter against a cycle model.
// Revision : 1.0
// ============================================================================
module tb_vga_write_arbiter;

    localparam int N        = 3;
    localparam int MAX_HOLD = 8;
`ifdef VGA_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           resetn;
    logic [N-1:0]   req, done, wen_in;
    logic [8*N-1:0] x_in;
    logic [7*N-1:0] y_in;
    logic [3*N-1:0] color_in;
    logic [N-1:0]   gnt;
    logic [1:0]     owner;
    logic           busy, writeEn, timeout;
    logic [7:0]     x_out;
    logic [6:0]     y_out;
    logic [2:0]     color_out;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    vga_write_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .resetn(resetn), .req(req), .done(done), .wen_in(wen_in),
        .x_in(x_in), .y_in(y_in), .color_in(color_in), .gnt(gnt), .owner(owner),
        .busy(busy), .x_out(x_out), .y_out(y_out), .color_out(color_out),
        .writeEn(writeEn), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Reference model: who holds the port, how long, and the cool-down before re-arbitration.
    bit m_active = 1'b0;
    int m_owner  = 0;
    int m_ptr    = 0;
    int m_cool   = 0;
    int m_len    = 0;
    bit m_to     = 1'b0;

    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return 0;
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_active <= 1'b0; m_owner <= 0; m_ptr <= 0;
            m_cool <= 0; m_len <= 0; m_to <= 1'b0;
        end else if (m_active) begin
            if (done[m_owner] || !req[m_owner] || (TO_EN && m_len >= MAX_HOLD)) begin
                m_active <= 1'b0;
                m_ptr    <= (m_owner + 1) % N;
                m_cool   <= 1;
                m_to     <= !(done[m_owner] || !req[m_owner]);
            end else begin
                m_len <= m_len + 1;
            end
        end else if (m_cool > 0) begin
            m_cool <= m_cool - 1;
            m_to   <= 1'b0;
        end else begin
            m_to <= 1'b0;
            if (req != '0) begin
                m_active <= 1'b1;
                m_owner  <= rr_pick(req, m_ptr);
                m_len    <= 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("gnt",       32'(gnt),       m_active ? (32'd1 << m_owner) : 32'd0);
        chk("owner",     32'(owner),     32'(m_owner));
        chk("busy",      32'(busy),      32'(m_active));
        chk("writeEn",   32'(writeEn),   m_active ? 32'(wen_in[m_owner]) : 32'd0);
        chk("x_out",     32'(x_out),     m_active ? 32'(x_in[8*m_owner +: 8]) : 32'd0);
        chk("y_out",     32'(y_out),     m_active ? 32'(y_in[7*m_owner +: 7]) : 32'd0);
        chk("color_out", 32'(color_out), m_active ? 32'(color_in[3*m_owner +: 3]) : 32'd0);
        chk("timeout",   32'(timeout),   32'(m_to));
    endtask

    task automatic tick();
        @(negedge clk);
        check_model();
    endtask

    task automatic wait_gnt(input int max);
        int c = 0;
        while (gnt == '0 && c < max) begin
            tick();
            c++;
        end
        chk("wait_gnt_nonzero", 32'(gnt != '0), 32'd1);
    endtask

    initial begin
        int order [4] = '{0, 1, 2, 0};
        int cnt;
        int len;
        logic [N-1:0] onehot;

        resetn = 1'b0; req = '0; done = '0; wen_in = '0;
        x_in = '0; y_in = '0; color_in = '0;
        repeat (3) tick();
        chk("reset_gnt", 32'(gnt), 32'd0);
        chk("reset_owner", 32'(owner), 32'd0);
        chk("reset_writeEn", 32'(writeEn), 32'd0);
        resetn = 1'b1;

        // Single client, 17-cycle grant.
        req = 3'b001;
        tick();
        chk("t1_gnt_latency", 32'(gnt), 32'b001);
        for (int c = 0; c < 16; c++) begin
            wen_in = N'($urandom); x_in = 24'($urandom); y_in = 21'($urandom); color_in = 9'($urandom);
            tick();
        end
        chk("t1_still_granted", 32'(gnt), 32'b001);
        done = 3'b001; req = 3'b000;
        tick();
        chk("t1_gap_gnt", 32'(gnt), 32'd0);
        chk("t1_gap_writeEn", 32'(writeEn), 32'd0);
        done = '0;

        // Round robin with all three requesting.
        resetn = 1'b0;
        tick();
        resetn = 1'b1; req = 3'b111; wen_in = 3'b111;
        for (int g = 0; g < 4; g++) begin
            cnt = 0;
            while (gnt == '0 && cnt < 10) begin
                cnt++;
                tick();
            end
            if (g > 0) chk("t2_spacing", 32'(cnt), 32'd2);
            onehot = N'(1) << order[g];
            chk("t2_order", 32'(owner), 32'(order[g]));
            chk("t2_gnt", 32'(gnt), 32'(onehot));
            repeat (3) tick();
            done = onehot;
            tick();
            done = '0;
            chk("t2_release", 32'(gnt), 32'd0);
        end
        req = '0;

        // Owner 1 muxed; client 0 traffic ignored.
        x_in = '0; y_in = '0; color_in = '0;
        x_in[15:8] = 8'd80; x_in[7:0] = 8'd5; y_in[13:7] = 7'd108; color_in[5:3] = 3'b010;
        wen_in = 3'b011; req = 3'b011;
        wait_gnt(5);
        chk("t3_owner", 32'(owner), 32'd1);
        chk("t3_x", 32'(x_out), 32'd80);
        chk("t3_y", 32'(y_out), 32'd108);
        chk("t3_color", 32'(color_out), 32'b010);
        chk("t3_wen", 32'(writeEn), 32'd1);
        done = 3'b010; req = 3'b001;
        tick();
        done = '0;

        // Foreign done ignored, then abandon.
        wait_gnt(5);
        chk("t4_gnt0", 32'(gnt), 32'b001);
        done = 3'b100;
        tick();
        chk("t4_foreign_done", 32'(gnt), 32'b001);
        done = '0; req = '0;
        tick();
        chk("t4_abandon", 32'(gnt), 32'd0);
        req = 3'b101;
        wait_gnt(5);
        chk("t4_rr_ptr1_pick", 32'(gnt), 32'b100);

        // Asynchronous reset mid-grant.
        x_in[23:16] = 8'd200; wen_in = 3'b100;
        tick();
        chk("t5_pre_wen", 32'(writeEn), 32'd1);
        chk("t5_pre_x", 32'(x_out), 32'd200);
        #2 resetn = 1'b0;
        #1;
        chk("t5_async_gnt", 32'(gnt), 32'd0);
        chk("t5_async_wen", 32'(writeEn), 32'd0);
        chk("t5_async_x", 32'(x_out), 32'd0);
        check_model();
        tick();
        resetn = 1'b1; req = 3'b110;
        wait_gnt(5);
        chk("t5_after_reset_owner", 32'(owner), 32'd1);

        // Hung drawer.
        req = '0;
        repeat (2) tick();
        req = 3'b011; wen_in = 3'b011;
        wait_gnt(5);
        chk("t6_owner0", 32'(owner), 32'd0);
        len = 0;
        while (gnt == 3'b001 && len < 120) begin
            len++;
            tick();
        end
`ifdef VGA_ARB_TIMEOUT_EN
        chk("t6_hold_len", 32'(len), 32'(MAX_HOLD));
        chk("t6_timeout_pulse", 32'(timeout), 32'd1);
        tick();
        chk("t6_timeout_clear", 32'(timeout), 32'd0);
        wait_gnt(5);
        chk("t6_next_owner", 32'(owner), 32'd1);
`else
        chk("t6_hold_persist", 32'(len), 32'd120);
        chk("t6_busy", 32'(busy), 32'd1);
        chk("t6_no_timeout", 32'(timeout), 32'd0);
`endif
        req = '0;
        repeat (3) tick();

        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (req[i]) begin
                    if ($urandom_range(0, 7) == 0) req[i] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    req[i] = 1'b1;
                end
                done[i] = ($urandom_range(0, 5) == 0);
            end
            wen_in = N'($urandom); x_in = 24'($urandom); y_in = 21'($urandom); color_in = 9'($urandom);
            tick();
        end
        req = '0; done = '0;
        repeat (4) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
